// File: rtl/memory_stage_pkg.sv
// Shared types for the RV64 memory stage: op/size encodings, pipeline payloads,
// data-bus request/response and the op decode helper.
package memory_stage_pkg;

    localparam logic [63:0] MIS_LOAD_CAUSE  = 64'd4;
    localparam logic [63:0] MIS_STORE_CAUSE = 64'd6;

    typedef enum logic [2:0] {
        SZ_B = 3'd0,
        SZ_H = 3'd1,
        SZ_W = 3'd2,
        SZ_D = 3'd3
    } msize_t;

    typedef enum logic [3:0] {
        OP_ALU, OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD
    } op_t;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        msize_t     size;
        logic [3:0] bytes;
        logic       sext;
    } mem_info_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] cause;
        logic [63:0] tval;
    } ex_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        op_t         op;
        logic        jump;
        logic        regwrite;
        logic [4:0]  dst;
        logic [63:0] aluout;
        logic [63:0] storedata;
        logic        skip;
        logic        csrwrite;
        logic [11:0] csr_dst;
        logic [63:0] csrdata;
        ex_t         ex_data;
    } execute_data_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        op_t         op;
        logic        jump;
        logic        regwrite;
        logic [4:0]  dst;
        logic [63:0] regdata;
        logic [63:0] address;
        logic        skip;
        logic        csrwrite;
        logic [11:0] csr_dst;
        logic [63:0] csrdata;
        ex_t         ex_data;
    } memory_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    function automatic mem_info_t mem_info(input op_t op);
        mem_info_t m;
        m = '{is_load: 1'b0, is_store: 1'b0, size: SZ_D, bytes: 4'd8, sext: 1'b0};
        case (op)
            OP_LB:  m = '{is_load: 1'b1, is_store: 1'b0, size: SZ_B, bytes: 4'd1, sext: 1'b1};
            OP_LH:  m = '{is_load: 1'b1, is_store: 1'b0, size: SZ_H, bytes: 4'd2, sext: 1'b1};
            OP_LW:  m = '{is_load: 1'b1, is_store: 1'b0, size: SZ_W, bytes: 4'd4, sext: 1'b1};
            OP_LD:  m = '{is_load: 1'b1, is_store: 1'b0, size: SZ_D, bytes: 4'd8, sext: 1'b0};
            OP_LBU: m = '{is_load: 1'b1, is_store: 1'b0, size: SZ_B, bytes: 4'd1, sext: 1'b0};
            OP_LHU: m = '{is_load: 1'b1, is_store: 1'b0, size: SZ_H, bytes: 4'd2, sext: 1'b0};
            OP_LWU: m = '{is_load: 1'b1, is_store: 1'b0, size: SZ_W, bytes: 4'd4, sext: 1'b0};
            OP_SB:  m = '{is_load: 1'b0, is_store: 1'b1, size: SZ_B, bytes: 4'd1, sext: 1'b0};
            OP_SH:  m = '{is_load: 1'b0, is_store: 1'b1, size: SZ_H, bytes: 4'd2, sext: 1'b0};
            OP_SW:  m = '{is_load: 1'b0, is_store: 1'b1, size: SZ_W, bytes: 4'd4, sext: 1'b0};
            OP_SD:  m = '{is_load: 1'b0, is_store: 1'b1, size: SZ_D, bytes: 4'd8, sext: 1'b0};
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/memory_stage_align.sv
// Combinational data-path helper: store lane shifting and strobes, load lane
// extraction with sign/zero extension, and misalignment detection.
module mem_align
    import memory_stage_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  op_t               op,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   storedata,
    input  logic [XLEN-1:0]   rdata,
    output logic              is_load,
    output logic              is_store,
    output logic              misaligned,
    output logic [2:0]        size,
    output logic [XLEN/8-1:0] strobe,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   ldata
);

    mem_info_t       info;
    logic [2:0]      off;
    logic [15:0]     mask;
    logic [XLEN-1:0] raw;

    always_comb begin
        info     = mem_info(op);
        off      = addr[2:0];
        is_load  = info.is_load;
        is_store = info.is_store;
        size     = info.size;

        case (info.size)
            SZ_H:    misaligned = addr[0];
            SZ_W:    misaligned = |addr[1:0];
            SZ_D:    misaligned = |off;
            default: misaligned = 1'b0;
        endcase
        misaligned = misaligned && (info.is_load || info.is_store);

        mask   = (16'd1 << info.bytes) - 16'd1;
        strobe = info.is_store ? (mask[XLEN/8-1:0] << off) : '0;
        wdata  = info.is_store ? (storedata << {off, 3'b000}) : '0;

        raw = rdata >> {off, 3'b000};
        case (info.size)
            SZ_B:    ldata = info.sext ? {{(XLEN-8){raw[7]}}, raw[7:0]}    : {{(XLEN-8){1'b0}}, raw[7:0]};
            SZ_H:    ldata = info.sext ? {{(XLEN-16){raw[15]}}, raw[15:0]} : {{(XLEN-16){1'b0}}, raw[15:0]};
            SZ_W:    ldata = info.sext ? {{(XLEN-32){raw[31]}}, raw[31:0]} : {{(XLEN-32){1'b0}}, raw[31:0]};
            default: ldata = raw;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory-access stage: issues dbus transactions, holds the pipe while one is
// outstanding, and registers the writeback payload.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned XLEN            = 64,
    parameter logic [63:0] MIS_LOAD_CAUSE  = memory_stage_pkg::MIS_LOAD_CAUSE,
    parameter logic [63:0] MIS_STORE_CAUSE = memory_stage_pkg::MIS_STORE_CAUSE
) (
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          valid_in,
    input  logic          flush,
    output logic          stall_out,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM,
    output logic          valid_out
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state;
    logic            kill;
    logic            is_load, is_store, is_mem, misaligned, issue;
    logic [2:0]      size;
    logic [7:0]      strobe;
    logic [XLEN-1:0] wdata, ldata;
    memory_data_t    base, mem_res, exc_res;

    mem_align #(.XLEN(XLEN)) u_align (
        .op         (dataE.op),
        .addr       (dataE.aluout),
        .storedata  (dataE.storedata),
        .rdata      (dresp.data),
        .is_load    (is_load),
        .is_store   (is_store),
        .misaligned (misaligned),
        .size       (size),
        .strobe     (strobe),
        .wdata      (wdata),
        .ldata      (ldata)
    );

    // The request is built from the held dataE, so it stays constant across WAIT;
    // gating with reset keeps the bus quiet while reset is held low.
    always_comb begin
        is_mem = is_load || is_store;
        issue  = (state == IDLE) && valid_in && !flush && is_mem && !misaligned;
        dreq   = '0;
        if (reset && (issue || state == WAIT)) begin
            dreq.valid  = 1'b1;
            dreq.addr   = {dataE.aluout[63:3], 3'b000};
            dreq.size   = size;
            dreq.strobe = strobe;
            dreq.data   = wdata;
        end
        stall_out = dreq.valid && !dresp.data_ok;
    end

    always_comb begin
        base = '{pc: dataE.pc, instr: dataE.instr, op: dataE.op, jump: dataE.jump,
                 regwrite: dataE.regwrite, dst: dataE.dst, regdata: dataE.aluout,
                 address: dataE.aluout, skip: dataE.skip, csrwrite: dataE.csrwrite,
                 csr_dst: dataE.csr_dst, csrdata: dataE.csrdata, ex_data: dataE.ex_data};

        mem_res         = base;
        mem_res.regdata = is_load ? ldata : '0;

        exc_res          = base;
        exc_res.regwrite = 1'b0;
        exc_res.regdata  = '0;
        exc_res.ex_data  = '{valid: 1'b1, cause: is_load ? MIS_LOAD_CAUSE : MIS_STORE_CAUSE,
                             tval: dataE.aluout};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            kill      <= 1'b0;
            dataM     <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in && !flush) begin
                        if (!is_mem) begin
                            dataM     <= base;
                            valid_out <= 1'b1;
                        end else if (misaligned) begin
                            dataM     <= exc_res;
                            valid_out <= 1'b1;
                        end else if (dresp.data_ok) begin
                            dataM     <= mem_res;
                            valid_out <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A flushed transaction still has to drain; it just retires silently.
                    if (dresp.data_ok) begin
                        state <= IDLE;
                        kill  <= 1'b0;
                        if (!kill && !flush) begin
                            dataM     <= mem_res;
                            valid_out <= 1'b1;
                        end
                    end else if (flush) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a vector table of single instructions plus
// hand-written flush-in-WAIT and reset-in-WAIT sequences.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE;
    logic          valid_in;
    logic          flush;
    logic          stall_out;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM;
    logic          valid_out;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    memory_stage #(
        .XLEN            (64),
        .MIS_LOAD_CAUSE  (64'd4),
        .MIS_STORE_CAUSE (64'd6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dataE     (dataE),
        .valid_in  (valid_in),
        .flush     (flush),
        .stall_out (stall_out),
        .dreq      (dreq),
        .dresp     (dresp),
        .dataM     (dataM),
        .valid_out (valid_out)
    );

    typedef struct {
        op_t         op;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] rdata;
        int unsigned lat;
        logic        req;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
        logic [63:0] regdata;
        logic        exc;
        logic [63:0] cause;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input op_t op, input logic [63:0] addr, input logic [63:0] sdata,
                                input logic [63:0] rdata, input int unsigned lat, input logic req,
                                input logic [2:0] size, input logic [7:0] strobe,
                                input logic [63:0] wdata, input logic [63:0] regdata,
                                input logic exc, input logic [63:0] cause);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.lat = lat;
        v.req = req; v.size = size; v.strobe = strobe; v.wdata = wdata;
        v.regdata = regdata; v.exc = exc; v.cause = cause;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_e(input op_t op, input logic [63:0] addr, input logic [63:0] sdata,
                         input logic [7:0] tag);
        dataE           = '0;
        dataE.pc        = 64'h8000_1000 + {56'd0, tag};
        dataE.instr     = 32'h0000_0013 + {24'd0, tag};
        dataE.op        = op;
        dataE.regwrite  = 1'b1;
        dataE.dst       = 5'd10;
        dataE.aluout    = addr;
        dataE.storedata = sdata;
        dataE.skip      = tag[0];
        dataE.csrwrite  = tag[1];
        dataE.csr_dst   = 12'h300;
        dataE.csrdata   = 64'hC5C5_0000 + {56'd0, tag};
    endtask

    task automatic run_vec(input vec_t v, input logic [7:0] tag);
        @(negedge clk);
        set_e(v.op, v.addr, v.sdata, tag);
        valid_in      = 1'b1;
        dresp.data    = v.rdata;
        dresp.data_ok = (v.lat == 0);
        for (int unsigned c = 0; c <= v.lat; c++) begin
            if (c > 0) begin
                @(negedge clk);
                dresp.data_ok = (c == v.lat);
            end
            #1;
            chk($sformatf("v%0d req_valid c%0d", tag, c), {63'd0, dreq.valid}, {63'd0, v.req});
            if (v.req) begin
                chk($sformatf("v%0d req_addr c%0d", tag, c), dreq.addr, v.addr & ~64'h7);
                chk($sformatf("v%0d req_size c%0d", tag, c), {61'd0, dreq.size}, {61'd0, v.size});
                chk($sformatf("v%0d req_strobe c%0d", tag, c), {56'd0, dreq.strobe}, {56'd0, v.strobe});
                chk($sformatf("v%0d req_data c%0d", tag, c), dreq.data, v.wdata);
                chk($sformatf("v%0d stall c%0d", tag, c), {63'd0, stall_out}, {63'd0, c != v.lat});
            end else begin
                chk($sformatf("v%0d stall", tag), {63'd0, stall_out}, 64'd0);
            end
            @(posedge clk);
            #1;
            if (c != v.lat)
                chk($sformatf("v%0d early_valid c%0d", tag, c), {63'd0, valid_out}, 64'd0);
        end
        chk($sformatf("v%0d valid_out", tag), {63'd0, valid_out}, 64'd1);
        chk($sformatf("v%0d pc", tag), dataM.pc, 64'h8000_1000 + {56'd0, tag});
        chk($sformatf("v%0d csrdata", tag), dataM.csrdata, 64'hC5C5_0000 + {56'd0, tag});
        chk($sformatf("v%0d skip", tag), {63'd0, dataM.skip}, {63'd0, tag[0]});
        chk($sformatf("v%0d ex_valid", tag), {63'd0, dataM.ex_data.valid}, {63'd0, v.exc});
        chk($sformatf("v%0d regwrite", tag), {63'd0, dataM.regwrite}, {63'd0, !v.exc});
        if (v.exc) begin
            chk($sformatf("v%0d cause", tag), dataM.ex_data.cause, v.cause);
            chk($sformatf("v%0d tval", tag), dataM.ex_data.tval, v.addr);
        end else begin
            chk($sformatf("v%0d regdata", tag), dataM.regdata, v.regdata);
        end
        valid_in      = 1'b0;
        dresp.data_ok = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d pulse_end", tag), {63'd0, valid_out}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //               op      addr                  sdata                  rdata                  lat req size  strobe  wdata                  regdata                exc cause
        vecs[0]  = mk(OP_LB,  64'h8000_0003, 64'h0,                 64'h0000_0000_8000_0000, 1, 1, 3'd0, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 0, 0);
        vecs[1]  = mk(OP_SH,  64'h8000_0006, 64'hBEEF,              64'h0,                   0, 1, 3'd1, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0,                  0, 0);
        vecs[2]  = mk(OP_LW,  64'h8000_0002, 64'h0,                 64'h0,                   0, 0, 3'd0, 8'h00, 64'h0,                 64'h0,                   1, 64'd4);
        vecs[3]  = mk(OP_LD,  64'h8000_0008, 64'h0,                 64'h1122_3344_5566_7788, 5, 1, 3'd3, 8'h00, 64'h0,                 64'h1122_3344_5566_7788, 0, 0);
        vecs[4]  = mk(OP_LBU, 64'h8000_0005, 64'h0,                 64'h0000_9A00_0000_0000, 0, 1, 3'd0, 8'h00, 64'h0,                 64'h0000_0000_0000_009A, 0, 0);
        vecs[5]  = mk(OP_LHU, 64'h8000_0002, 64'h0,                 64'h0000_0000_8001_0000, 1, 1, 3'd1, 8'h00, 64'h0,                 64'h0000_0000_0000_8001, 0, 0);
        vecs[6]  = mk(OP_LH,  64'h8000_0002, 64'h0,                 64'h0000_0000_8001_0000, 0, 1, 3'd1, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_8001, 0, 0);
        vecs[7]  = mk(OP_LWU, 64'h8000_0004, 64'h0,                 64'hDEAD_BEEF_0000_0000, 2, 1, 3'd2, 8'h00, 64'h0,                 64'h0000_0000_DEAD_BEEF, 0, 0);
        vecs[8]  = mk(OP_LW,  64'h8000_0004, 64'h0,                 64'hDEAD_BEEF_0000_0000, 0, 1, 3'd2, 8'h00, 64'h0,                 64'hFFFF_FFFF_DEAD_BEEF, 0, 0);
        vecs[9]  = mk(OP_SB,  64'h8000_0001, 64'h1234_5678_9ABC_DEF0, 64'h0,                 1, 1, 3'd0, 8'h02, 64'h3456_789A_BCDE_F000, 64'h0,                  0, 0);
        vecs[10] = mk(OP_SW,  64'h8000_0004, 64'hCAFE_BABE,         64'h0,                   0, 1, 3'd2, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'h0,                  0, 0);
        vecs[11] = mk(OP_SD,  64'h8000_0000, 64'h0123_4567_89AB_CDEF, 64'h0,                 2, 1, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0,                  0, 0);
        vecs[12] = mk(OP_SD,  64'h8000_0004, 64'h0,                 64'h0,                   0, 0, 3'd0, 8'h00, 64'h0,                 64'h0,                   1, 64'd6);
        vecs[13] = mk(OP_SH,  64'h8000_0001, 64'h0,                 64'h0,                   0, 0, 3'd0, 8'h00, 64'h0,                 64'h0,                   1, 64'd6);
        vecs[14] = mk(OP_ALU, 64'h0000_1234, 64'h0,                 64'h0,                   0, 0, 3'd0, 8'h00, 64'h0,                 64'h0000_0000_0000_1234, 0, 0);

        reset    = 1'b0;
        valid_in = 1'b0;
        flush    = 1'b0;
        dresp    = '0;
        dataE    = '0;
        #12;
        chk("reset valid_out", {63'd0, valid_out}, 64'd0);
        chk("reset req_valid", {63'd0, dreq.valid}, 64'd0);
        chk("reset stall", {63'd0, stall_out}, 64'd0);
        chk("reset req_addr", dreq.addr, 64'd0);
        tests++;
        if (dataM !== '0) begin
            fails++;
            $display("FAIL reset dataM: got pc %h regdata %h, expected all zero", dataM.pc, dataM.regdata);
        end
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 15; i++)
            run_vec(vecs[i], 8'(i));

        // Flush during WAIT: bus drains, nothing retires
        @(negedge clk);
        set_e(OP_SW, 64'h8000_0000, 64'h55, 8'd20);
        valid_in = 1'b1;
        dresp    = '0;
        #1;
        chk("flush issue", {63'd0, dreq.valid}, 64'd1);
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            flush         = (c == 2);
            dresp.data_ok = (c == 4);
            #1;
            chk($sformatf("flush wait req c%0d", c), {63'd0, dreq.valid}, 64'd1);
            chk($sformatf("flush wait stall c%0d", c), {63'd0, stall_out}, {63'd0, c != 4});
            @(posedge clk);
            #1;
            chk($sformatf("flush valid_out c%0d", c), {63'd0, valid_out}, 64'd0);
        end
        flush         = 1'b0;
        valid_in      = 1'b0;
        dresp.data_ok = 1'b0;
        #1;
        chk("flush idle req", {63'd0, dreq.valid}, 64'd0);
        chk("flush idle stall", {63'd0, stall_out}, 64'd0);
        @(posedge clk);
        #1;
        chk("flush after valid_out", {63'd0, valid_out}, 64'd0);
        run_vec(vecs[0], 8'd21);

        // Reset while WAIT is outstanding
        @(negedge clk);
        set_e(OP_LD, 64'h8000_0010, 64'h0, 8'd30);
        valid_in = 1'b1;
        dresp    = '0;
        @(posedge clk);
        #1;
        chk("rst_wait valid_out", {63'd0, valid_out}, 64'd0);
        @(negedge clk);
        #1;
        chk("rst_wait stall_before", {63'd0, stall_out}, 64'd1);
        reset = 1'b0;
        #1;
        chk("rst_wait req_valid", {63'd0, dreq.valid}, 64'd0);
        chk("rst_wait stall", {63'd0, stall_out}, 64'd0);
        chk("rst_wait valid_out_now", {63'd0, valid_out}, 64'd0);
        @(negedge clk);
        valid_in = 1'b0;
        reset    = 1'b1;
        run_vec(vecs[14], 8'd31);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Memory-access stage of the 5-stage RV64 pipeline. Sits between the execute pipeline register and the combinational writeback stage, and produces memory_data_t.
- Issues loads and stores on the data bus (dbus) and holds the pipeline while a transaction is outstanding.
- Aligns store data and builds byte strobes; extracts and extends load data.
- Raises load/store misaligned exceptions. Non-memory instructions pass through with one cycle of latency.

Parameters:
- XLEN, 64, datapath and dbus data width.
- MIS_LOAD_CAUSE, 4, mcause code for a misaligned load.
- MIS_STORE_CAUSE, 6, mcause code for a misaligned store.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- dataE  in  execute_data_t  execute-stage payload: pc, instruction, op, jump, regwrite, dst, aluout (effective address or result), storedata, skip, csr fields, ex_data
- valid_in  in  1  dataE holds a live instruction
- flush  in  1  kill the current instruction (trap/redirect from commit)
- stall_out  out  1  upstream must hold dataE/valid_in stable
- dreq  out  dbus_req_t  {valid, addr, size[2:0], strobe[7:0], data[63:0]}
- dresp  in  dbus_resp_t  {data_ok, data[63:0]}
- dataM  out  memory_data_t  registered payload to writeback
- valid_out  out  1  dataM is live this cycle

Behaviour:
- Reset values (asynchronous, reset low): FSM=IDLE, dreq.valid=0, dreq fields=0, dataM=0, valid_out=0, stall_out=0.
- FSM has two states: IDLE and WAIT.
- Address: addr = dataE.aluout. off = addr[2:0].
- Access size by op: B=1, H=2, W=4, D=8 bytes.
- Misaligned when: H and addr[0]!=0; W and addr[1:0]!=0; D and off!=0.
- IDLE, valid_in=1, not a memory op, not flush:
  - dataM <= dataE, with regdata=aluout, at the next edge; valid_out=1 for one cycle.
  - stall_out=0.
- IDLE, memory op, misaligned:
  - No bus request.
  - Next edge: dataM <= dataE with ex_data.valid=1, cause = MIS_LOAD_CAUSE or MIS_STORE_CAUSE, tval = addr, regwrite=0; valid_out=1.
- IDLE, memory op, aligned, not flush:
  - Combinationally: dreq.valid=1 and stall_out=1; next edge goes to WAIT.
  - dreq.addr = {addr[63:3], 3'b0}. dreq.size = log2(bytes).
  - Store: data = storedata << (off*8); strobe = ((1<<bytes)-1) << off.
  - Load: strobe = 0.
- WAIT:
  - dreq.valid=1 with addr/size/strobe/data held constant (derived from the held dataE).
  - stall_out=1 until dresp.data_ok.
- Completion (dresp.data_ok=1, in IDLE issue cycle or in WAIT):
  - stall_out=0 that cycle; next edge: FSM=IDLE, dreq.valid=0.
  - dataM registered; valid_out=1 for exactly one cycle.
  - Load: raw = dresp.data >> (off*8), truncated to access size; LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend, LD passes through.
  - Store: regdata = 0; address = addr is carried for the difftest/commit log.
- data_ok in the same cycle the request is first raised is legal and completes in one cycle.
- valid_out=0 whenever no instruction completes that edge (bubble); dataM contents are don't-care when valid_out=0 but are still driven by register.
- flush in IDLE: no request is issued; valid_out=0 next cycle.
- flush in WAIT: the bus transaction cannot be aborted.
  - A sticky kill flag is set.
  - Remain in WAIT until data_ok, then return to IDLE with valid_out=0.
  - The flag clears on completion.
- valid_in=0 in IDLE: no request; valid_out=0.
- Reset mid-WAIT: return immediately to IDLE; the outstanding response is the bus's responsibility to discard.
- CSR fields (csrwrite, csr_dst, csrdata) and skip pass through unchanged with the instruction.

Decomposition:
- The common package holds:
  - the access-size enum;
  - MIS_LOAD_CAUSE and MIS_STORE_CAUSE;
  - a helper function from op to {is_load, is_store, bytes, signed}.
- The pipes package holds execute_data_t and memory_data_t. dataM is already defined there; this block adds no new fields.
- One sub-module, mem_align:
  - purely combinational;
  - store shifting and strobe generation;
  - load extraction and sign/zero extension;
  - misalignment detection.
- The FSM, kill flag and output register stay in memory_stage.

Test Plan:
- LB, addr 0x80000003, dresp.data=0x0000_0000_8000_0000 with data_ok 1 cycle later -> dreq.addr=0x80000000, size=0, dataM.regdata=0xFFFF_FFFF_FFFF_FF80, valid_out pulses once.
- SH, addr 0x80000006, storedata=0xBEEF -> dreq.strobe=0xC0, dreq.data=0xBEEF_0000_0000_0000, regdata=0.
- LW, addr 0x80000002 -> dreq.valid never asserted; next cycle valid_out=1, ex_data cause=4, tval=0x80000002.
- LD with data_ok delayed 5 cycles -> stall_out high 5 cycles, dreq fields constant throughout, valid_out is a single-cycle pulse after data_ok.
- SW issued, flush asserted in cycle 2 of WAIT, data_ok in cycle 4 -> FSM returns to IDLE, valid_out stays 0.
- Reset asserted in WAIT -> dreq.valid=0, valid_out=0 and stall_out=0 immediately; a subsequent ADD passes through in 1 cycle.
